// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: funct3 codes, multiply/divide FSM state encoding,
// and small decode helpers.
package rv32m_pkg;

  localparam logic [2:0] F_MUL    = 3'd0;
  localparam logic [2:0] F_MULH   = 3'd1;
  localparam logic [2:0] F_MULHSU = 3'd2;
  localparam logic [2:0] F_MULHU  = 3'd3;
  localparam logic [2:0] F_DIV    = 3'd4;
  localparam logic [2:0] F_DIVU   = 3'd5;
  localparam logic [2:0] F_REM    = 3'd6;
  localparam logic [2:0] F_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Upper funct3 bit separates the divide group from the multiply group.
  function automatic logic is_div(input logic [2:0] funct);
    return funct[2];
  endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// EX-stage RV32M unit: iterative shift-add multiplier and restoring divider,
// one bit per cycle, holding the front of the pipeline via stall_o.
module ex_muldiv_unit
  import rv32m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      funct_i,
  input  logic [XLEN-1:0] opr_1_i,
  input  logic [XLEN-1:0] opr_2_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            result_valid_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN) + 1;

  state_t            r_state;
  state_t            w_state_next;
  logic [CW-1:0]     r_count;
  logic [2:0]        r_funct;
  logic [XLEN-1:0]   r_opa;      // |rs1|: multiplicand, or dividend magnitude
  logic [XLEN-1:0]   r_opb;      // |rs2|: divisor (multiplier is preloaded into r_lo)
  logic [XLEN-1:0]   r_hi;       // product high half / partial remainder
  logic [XLEN-1:0]   r_lo;       // product low half / dividend-then-quotient
  logic              r_neg_a;
  logic              r_neg_b;
  logic              r_ovf;      // DIV/REM of most-negative by -1
  logic [XLEN-1:0]   r_result;

  logic              w_accept;
  logic              w_signed_a;
  logic              w_signed_b;
  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_abs_a;
  logic [XLEN-1:0]   w_abs_b;
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN-1:0]   w_mul_hi;
  logic [XLEN-1:0]   w_mul_lo;
  logic [XLEN:0]     w_div_cand;
  logic              w_div_ge;
  logic [XLEN-1:0]   w_div_hi;
  logic [XLEN-1:0]   w_div_lo;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_dividend;
  logic [XLEN-1:0]   w_final;

  assign w_accept = (r_state == IDLE) && start_i && !flush_i;

  // Operand decode: which operands are signed, and their magnitudes.
  always_comb begin
    w_signed_a = (funct_i == F_MULH) || (funct_i == F_MULHSU) ||
                 (funct_i == F_DIV)  || (funct_i == F_REM);
    w_signed_b = (funct_i == F_MULH) || (funct_i == F_DIV) || (funct_i == F_REM);
    w_sa       = w_signed_a && opr_1_i[XLEN-1];
    w_sb       = w_signed_b && opr_2_i[XLEN-1];
    w_abs_a    = w_sa ? -opr_1_i : opr_1_i;
    w_abs_b    = w_sb ? -opr_2_i : opr_2_i;
  end

  // One multiply step: add multiplicand on the low bit, shift {hi,lo} right.
  always_comb begin
    w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opa} : '0);
    w_mul_hi  = w_mul_sum[XLEN:1];
    w_mul_lo  = {w_mul_sum[0], r_lo[XLEN-1:1]};
  end

  // One restoring-divide step: bring in the next dividend bit, subtract if it fits.
  always_comb begin
    w_div_cand = {r_hi, r_lo[XLEN-1]};
    w_div_ge   = w_div_cand >= {1'b0, r_opb};
    w_div_hi   = w_div_ge ? w_div_cand[XLEN-1:0] - r_opb : w_div_cand[XLEN-1:0];
    w_div_lo   = {r_lo[XLEN-2:0], w_div_ge};
  end

  // Sign fix-up and special cases on the value produced by the final iteration.
  always_comb begin
    w_prod     = {w_mul_hi, w_mul_lo};
    if (r_neg_a ^ r_neg_b) w_prod = -w_prod;
    w_quo      = (r_neg_a ^ r_neg_b) ? -w_div_lo : w_div_lo;
    w_rem      = r_neg_a ? -w_div_hi : w_div_hi;
    w_dividend = r_neg_a ? -r_opa : r_opa;
    w_final    = '0;
    case (r_funct)
      F_MUL:                     w_final = w_prod[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
      F_DIV, F_DIVU: begin
        if (r_opb == '0)  w_final = '1;
        else if (r_ovf)   w_final = {1'b1, {(XLEN-1){1'b0}}};
        else              w_final = w_quo;
      end
      default: begin
        if (r_opb == '0)  w_final = w_dividend;
        else if (r_ovf)   w_final = '0;
        else              w_final = w_rem;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic; flush wins from any state.
  always_comb begin
    // NOTE: default assignment first so every path drives the signal and no latch is inferred.
    w_state_next = r_state;
    if (flush_i) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (start_i) w_state_next = BUSY;
        BUSY:    if (r_count == CW'(1)) w_state_next = DONE;
        DONE:    w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Outputs; a flush in DONE suppresses the valid pulse.
  always_comb begin
    stall_o        = 1'b0;
    result_valid_o = 1'b0;
    case (r_state)
      IDLE:    stall_o = start_i && !flush_i;
      BUSY:    stall_o = 1'b1;
      DONE:    result_valid_o = !flush_i;
      default: ;
    endcase
  end

  // Datapath: latch operands on accept, iterate while busy, capture the result on the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_funct  <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_ovf    <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_count <= CW'(XLEN);
      r_funct <= funct_i;
      r_opa   <= w_abs_a;
      r_opb   <= w_abs_b;
      r_hi    <= '0;
      r_lo    <= is_div(funct_i) ? w_abs_a : w_abs_b;
      r_neg_a <= w_sa;
      r_neg_b <= w_sb;
      r_ovf   <= ((funct_i == F_DIV) || (funct_i == F_REM)) &&
                 (opr_1_i == {1'b1, {(XLEN-1){1'b0}}}) && (opr_2_i == '1);
    end else if ((r_state == BUSY) && !flush_i) begin
      r_count <= r_count - CW'(1);
      r_hi    <= is_div(r_funct) ? w_div_hi : w_mul_hi;
      r_lo    <= is_div(r_funct) ? w_div_lo : w_mul_lo;
      if (r_count == CW'(1)) r_result <= w_final;
    end
  end

  assign result_o = r_result;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed RV32M cases, flush/reset
// behaviour, back-to-back timing, and random ops against an arithmetic model.
module tb_ex_muldiv_unit;
  import rv32m_pkg::*;

  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 1;   // cycles from start to the valid pulse

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start_i = 1'b0;
  logic [2:0]      funct_i = '0;
  logic [XLEN-1:0] opr_1_i = '0;
  logic [XLEN-1:0] opr_2_i = '0;
  logic            flush_i = 1'b0;
  logic            stall_o;
  logic            result_valid_o;
  logic [XLEN-1:0] result_o;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  ex_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .funct_i        (funct_i),
    .opr_1_i        (opr_1_i),
    .opr_2_i        (opr_2_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .result_valid_o (result_valid_o),
    .result_o       (result_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // RV32M semantics from plain 64-bit / 32-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa = $signed(a);
    longint      sb = $signed(b);
    longint      ub = longint'({32'b0, b});
    int          ia = $signed(a);
    int          ib = $signed(b);
    logic [63:0] p;
    logic        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      F_MUL:    begin p = {32'b0, a} * {32'b0, b}; return p[31:0];  end
      F_MULH:   begin p = sa * sb;                 return p[63:32]; end
      F_MULHSU: begin p = sa * ub;                 return p[63:32]; end
      F_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      F_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
      F_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F_REM:    return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
      default:  return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Present an op (caller is #1 after an edge) and wait, bounded, for the valid pulse.
  // Returns in the valid cycle with start_i still high.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int stalls, output logic stall_at_valid);
    funct_i = f;
    opr_1_i = a;
    opr_2_i = b;
    start_i = 1'b1;
    lat     = 0;
    stalls  = 0;
    #1;
    while (!result_valid_o && lat < 100) begin
      if (stall_o) stalls++;
      @(posedge clk);
      #1;
      lat++;
    end
    stall_at_valid = stall_o;
  endtask

  // Full op with result, latency, stall and pulse-width checks.
  task automatic exec(input string tag, input logic [2:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp);
    int   lat, stalls;
    logic sv;
    run_op(f, a, b, lat, stalls, sv);
    check({tag, "_res"}, result_o, exp);
    check({tag, "_lat"}, 32'(lat), 32'(LAT));
    check({tag, "_stallcnt"}, 32'(stalls), 32'(LAT));
    check({tag, "_stall_at_valid"}, {31'b0, sv}, 32'd0);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    #1;
    check({tag, "_pulse"}, {31'b0, result_valid_o}, 32'd0);
    check({tag, "_idle_stall"}, {31'b0, stall_o}, 32'd0);
  endtask

  typedef struct {
    string       tag;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t dir[] = '{
    '{"mul_7_m3",        F_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
    '{"mulh_min_min",    F_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000},
    '{"mulhsu_m1",       F_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF},
    '{"mulhu_max",       F_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE},
    '{"div_m7_2",        F_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD},
    '{"rem_m7_2",        F_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF},
    '{"divu_100_7",      F_DIVU,   32'd100,        32'd7,         32'd14},
    '{"remu_100_7",      F_REMU,   32'd100,        32'd7,         32'd2},
    '{"div_by0",         F_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF},
    '{"divu_by0",        F_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF},
    '{"remu_by0",        F_REMU,   32'h1234,       32'd0,         32'h1234},
    '{"rem_by0_neg",     F_REM,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9},
    '{"div_ovf",         F_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
    '{"rem_ovf",         F_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0}
  };

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'(1 + $urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] prev, r1;
    int          lat, stalls, c1, c2, vcount;
    logic        sv;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", {31'b0, stall_o}, 32'd0);
    check("rst_valid", {31'b0, result_valid_o}, 32'd0);
    check("rst_result", result_o, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases with spec-derived expectations.
    foreach (dir[i]) exec(dir[i].tag, dir[i].f, dir[i].a, dir[i].b, dir[i].exp);

    // Flush in BUSY cycle 10: back to IDLE, no pulse, result held.
    prev    = result_o;
    funct_i = F_DIVU;
    opr_1_i = 32'd1000;
    opr_2_i = 32'd3;
    start_i = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("flush_busy_stall", {31'b0, stall_o}, 32'd1);
    flush_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    #1;
    check("flush_stall", {31'b0, stall_o}, 32'd0);
    check("flush_result", result_o, prev);
    vcount = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (result_valid_o) vcount++;
    end
    check("flush_no_pulse", 32'(vcount), 32'd0);
    check("flush_result_late", result_o, prev);

    // Asynchronous reset in BUSY cycle 5, then a normal op.
    funct_i = F_MUL;
    opr_1_i = 32'd9;
    opr_2_i = 32'd11;
    start_i = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rst_n   = 1'b0;
    start_i = 1'b0;
    #1;
    check("arst_stall", {31'b0, stall_o}, 32'd0);
    check("arst_valid", {31'b0, result_valid_o}, 32'd0);
    check("arst_result", result_o, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exec("post_rst_mul", F_MUL, 32'd9, 32'd11, 32'd99);

    // Back-to-back: second op presented in the IDLE cycle right after DONE.
    run_op(F_DIVU, 32'd100, 32'd7, lat, stalls, sv);
    c1 = cyc;
    r1 = result_o;
    check("b2b_first", r1, 32'd14);
    @(posedge clk);
    #1;
    run_op(F_REMU, 32'd100, 32'd7, lat, stalls, sv);
    c2 = cyc;
    check("b2b_second", result_o, 32'd2);
    check("b2b_lat", 32'(lat), 32'(LAT));
    // Valid-to-valid distance XLEN+2 edges, i.e. XLEN+3 cycles counting both endpoints.
    check("b2b_gap", 32'(c2 - c1), 32'(XLEN + 2));
    @(posedge clk);
    #1;
    start_i = 1'b0;

    // Random ops against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      exec($sformatf("rand%0d_f%0d", i, f), f, a, b, ref_model(f, a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
